// File: rtl/addsub_accumulator_if.sv
// Handshake bundle for the add/subtract accumulator: an operand stream in,
// one registered result per packet out.
interface addsub_accumulator_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   // Operand stream (upstream producer -> accumulator)
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic             in_last;

   // Result stream (accumulator -> results path)
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_overflow;
   logic [CNT_W-1:0] out_count;

   // Producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid, in_data, in_mode, in_last, out_ready,
      input  in_ready, out_valid, out_result, out_carry, out_overflow, out_count
   );

   // Accumulator side
   modport slave (
      input  in_valid, in_data, in_mode, in_last, out_ready,
      output in_ready, out_valid, out_result, out_carry, out_overflow, out_count
   );
endinterface

// File: rtl/addsub_accumulator.sv
// Streaming 2's-complement add/subtract accumulator.
// Handshake rule on both streams: a transfer happens on a rising clk edge
// where valid && ready are both high; valid, once raised, holds its payload
// stable until that transfer. in_ready depends on the state register only.
module addsub_accumulator #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   addsub_accumulator_if.slave  bus,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] acc_q;
   logic             carry_q;
   logic             ovf_q;
   logic [CNT_W-1:0] count_q;
   logic             out_valid_q;

   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] opa_d;
   logic [WIDTH-1:0] opb_d;
   logic [WIDTH:0]   sum_full_d;
   logic [WIDTH-1:0] sum_low_d;
   logic             beat_carry_d;
   logic             beat_ovf_d;
   logic [CNT_W-1:0] count_inc_d;

   assign in_ready = (state_q != ST_DONE);
   assign accept   = bus.in_valid && in_ready;

   // Beat datapath: subtraction is a + ~b + 1; first beat of a packet starts from zero
   always_comb begin
      opa_d        = (state_q == ST_IDLE) ? '0 : acc_q;
      opb_d        = bus.in_mode ? ~bus.in_data : bus.in_data;
      sum_full_d   = {1'b0, opa_d} + {1'b0, opb_d} + {{WIDTH{1'b0}}, bus.in_mode};
      // Sum of the low WIDTH-1 bits; its top bit is the carry into the MSB
      sum_low_d    = {1'b0, opa_d[WIDTH-2:0]} + {1'b0, opb_d[WIDTH-2:0]}
                     + {{(WIDTH-1){1'b0}}, bus.in_mode};
      beat_carry_d = sum_full_d[WIDTH];
      beat_ovf_d   = sum_low_d[WIDTH-1] ^ sum_full_d[WIDTH];
      count_inc_d  = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
   end

   // Packet FSM with registered accumulator, flags, count and out_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  acc_q   <= sum_full_d[WIDTH-1:0];
                  carry_q <= beat_carry_d;
                  ovf_q   <= beat_ovf_d;
                  count_q <= {{(CNT_W-1){1'b0}}, 1'b1};
                  if (bus.in_last) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_ACCUM;
                  end
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc_q   <= sum_full_d[WIDTH-1:0];
                  carry_q <= beat_carry_d;
                  ovf_q   <= ovf_q | beat_ovf_d;
                  count_q <= count_inc_d;
                  if (bus.in_last) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (out_valid_q && bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_result   = acc_q;
   assign bus.out_carry    = carry_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_count    = count_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator: directed packets from the test plan plus
// randomized packets, checked against an integer-arithmetic reference model.
module tb_addsub_accumulator;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;
   localparam int EXP_W = WIDTH + 2 + CNT_W;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   addsub_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   addsub_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: {result, carry, overflow, count} per completed packet
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] cur_exp;
   int n_vec = 0;
   int n_err = 0;

   // Reference model state (plain integers)
   int m_acc;
   int m_cnt;
   bit m_carry;
   bit m_ovf;
   bit m_open;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_open = 1'b0;
      exp_q.delete();
   endtask

   // Signed arithmetic on whole integers; carry/overflow from range tests
   task automatic model_beat(input logic [15:0] d, input logic mode, input logic last);
      int a, b, sa, sb, u, s;
      bit c, v;
      a  = m_open ? m_acc : 0;
      b  = int'(d);
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (b >= 32768) ? b - 65536 : b;
      if (!mode) begin
         u = a + b;
         c = (u > 65535);
         s = sa + sb;
      end else begin
         u = a - b;
         c = (a >= b);
         s = sa - sb;
      end
      u = (u + 65536) % 65536;
      v = (s > 32767) || (s < -32768);
      if (m_open) begin
         m_ovf = m_ovf | v;
         m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else begin
         m_ovf = v;
         m_cnt = 1;
      end
      m_acc   = u;
      m_carry = c;
      m_open  = 1'b1;
      if (last) begin
         exp_q.push_back({16'(m_acc), m_carry, m_ovf, 8'(m_cnt)});
         m_open = 1'b0;
      end
   endtask

   // Driver: present one beat at the falling edge, transfer at the next rise
   task automatic send_beat(input logic [15:0] d, input logic mode, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_mode  = mode;
      bus.in_last  = last;
      check("in_ready_at_beat", 32'(bus.in_ready), 32'd1);
      model_beat(d, mode, last);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Bubble cycles with junk on the data lines
   task automatic bubbles(input int n);
      repeat (n) begin
         bus.in_data = 16'($urandom);
         bus.in_mode = 1'($urandom);
         bus.in_last = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string tag);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
         cur_exp = '0;
      end else begin
         cur_exp = exp_q.pop_front();
         check({tag, "_result"}, 32'(bus.out_result), 32'(cur_exp[25:10]));
         check({tag, "_carry"}, 32'(bus.out_carry), 32'(cur_exp[9]));
         check({tag, "_overflow"}, 32'(bus.out_overflow), 32'(cur_exp[8]));
         check({tag, "_count"}, 32'(bus.out_count), 32'(cur_exp[7:0]));
      end
   endtask

   // Hold the result under backpressure, then complete the out handshake
   task automatic hold_and_release(input string tag, input int hold);
      repeat (hold) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
         check({tag, "_hold_result"}, 32'(bus.out_result), 32'(cur_exp[25:10]));
         check({tag, "_hold_carry"}, 32'(bus.out_carry), 32'(cur_exp[9]));
         check({tag, "_hold_overflow"}, 32'(bus.out_overflow), 32'(cur_exp[8]));
         check({tag, "_hold_count"}, 32'(bus.out_count), 32'(cur_exp[7:0]));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_result"}, 32'(bus.out_result), 32'd0);
      check({tag, "_carry"}, 32'(bus.out_carry), 32'd0);
      check({tag, "_overflow"}, 32'(bus.out_overflow), 32'd0);
      check({tag, "_count"}, 32'(bus.out_count), 32'd0);
   endtask

   initial begin
      int len;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();

      // Power-on reset
      repeat (2) @(negedge clk);
      check_reset_values("por");
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset mid-cycle while a result is held
      send_beat(16'h1234, 1'b0, 1'b1);
      check_result("pre_rst");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Mixed packet: 100 + 200 - 50, back-to-back
      send_beat(16'd100, 1'b0, 1'b0);
      send_beat(16'd200, 1'b0, 1'b0);
      send_beat(16'd50, 1'b1, 1'b1);
      check_result("mixed");
      check("mixed_const_result", 32'(bus.out_result), 32'h00FA);
      check("mixed_const_count", 32'(bus.out_count), 32'd3);
      check("mixed_const_ovf", 32'(bus.out_overflow), 32'd0);
      check("mixed_const_carry", 32'(bus.out_carry), 32'd1);
      hold_and_release("mixed", 0);

      // Overflow on the last beat
      send_beat(16'h7FFF, 1'b0, 1'b0);
      send_beat(16'h0001, 1'b0, 1'b1);
      check_result("ovf");
      check("ovf_const_result", 32'(bus.out_result), 32'h8000);
      check("ovf_const_ovf", 32'(bus.out_overflow), 32'd1);
      check("ovf_const_carry", 32'(bus.out_carry), 32'd0);
      hold_and_release("ovf", 0);

      // Sticky overflow
      send_beat(16'h7FFF, 1'b0, 1'b0);
      send_beat(16'h0001, 1'b0, 1'b0);
      send_beat(16'h0001, 1'b1, 1'b1);
      check_result("sticky");
      check("sticky_const_result", 32'(bus.out_result), 32'h7FFF);
      check("sticky_const_ovf", 32'(bus.out_overflow), 32'd1);
      check("sticky_const_carry", 32'(bus.out_carry), 32'd1);
      check("sticky_const_count", 32'(bus.out_count), 32'd3);
      hold_and_release("sticky", 0);

      // Single-beat subtract held under backpressure for 5 cycles
      send_beat(16'd5, 1'b1, 1'b1);
      check_result("single");
      check("single_const_result", 32'(bus.out_result), 32'hFFFB);
      check("single_const_count", 32'(bus.out_count), 32'd1);
      check("single_const_carry", 32'(bus.out_carry), 32'd0);
      hold_and_release("single", 5);

      // Reset mid-packet, starting right after the handshake above
      send_beat(16'h1111, 1'b0, 1'b0);
      send_beat(16'h2222, 1'b1, 1'b0);
      rst_n = 1'b0;
      #2 check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_result", 32'(bus.out_result), 32'd0);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      send_beat(16'd7, 1'b0, 1'b1);
      check_result("after_rst");
      check("after_rst_const_result", 32'(bus.out_result), 32'd7);
      check("after_rst_const_count", 32'(bus.out_count), 32'd1);
      check("after_rst_const_ovf", 32'(bus.out_overflow), 32'd0);
      hold_and_release("after_rst", 1);

      // Count saturation on a long back-to-back packet
      for (int i = 0; i < 260; i++) begin
         send_beat(16'($urandom), 1'($urandom), (i == 259));
      end
      check_result("long");
      check("long_const_count", 32'(bus.out_count), 32'd255);
      hold_and_release("long", 0);

      // Randomized packets with bubbles and backpressure
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            bubbles($urandom_range(0, 2));
            send_beat(16'($urandom), 1'($urandom), (i == len - 1));
         end
         check_result("rand");
         hold_and_release("rand", $urandom_range(0, 3));
         bubbles($urandom_range(0, 1));
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
